// File: rtl/jt51_pkg.sv
//------------------------------------------------------------------------------
// jt51_pkg : shared register map constants and channel strobe layout
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jt51_pkg;

   // Channel register groups: each group covers 8 consecutive addresses
   localparam logic [7:0] c_addr_rl  = 8'h20;
   localparam logic [7:0] c_addr_kc  = 8'h28;
   localparam logic [7:0] c_addr_kf  = 8'h30;
   localparam logic [7:0] c_addr_ams = 8'h38;

   localparam int c_stb_w   = 7;
   localparam int c_stb_rl  = 0;
   localparam int c_stb_fb  = 1;
   localparam int c_stb_con = 2;
   localparam int c_stb_kc  = 3;
   localparam int c_stb_kf  = 4;
   localparam int c_stb_ams = 5;
   localparam int c_stb_pms = 6;

   typedef logic [c_stb_w-1:0] stb_t;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } entry_t;

   // Maps the low address bits of a 0x20-0x3F write to the field strobes it updates
   function automatic stb_t decode_fields(input logic [4:0] a);
      logic [7:0] v;
      stb_t       s;
      v = {c_addr_rl[7:5], a};
      s = '0;
      if (v >= c_addr_ams) begin
         s[c_stb_ams] = 1'b1;
         s[c_stb_pms] = 1'b1;
      end else if (v >= c_addr_kf) begin
         s[c_stb_kf] = 1'b1;
      end else if (v >= c_addr_kc) begin
         s[c_stb_kc] = 1'b1;
      end else begin
         s[c_stb_rl]  = 1'b1;
         s[c_stb_fb]  = 1'b1;
         s[c_stb_con] = 1'b1;
      end
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jt51_sched_fifo.sv
//------------------------------------------------------------------------------
// jt51_sched_fifo : pending-write queue with head and second-entry lookahead
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jt51_sched_fifo
   import jt51_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  entry_t                   i_data,
   output entry_t                   o_head,
   output entry_t                   o_next,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full_cnt = DEPTH[AW:0];

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == c_full_cnt);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd];
   assign o_next    = r_mem[AW'(r_rd + 1'b1)];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop on the same edge frees the slot the push needs, even when full
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= AW'(r_wr + 1'b1);
         if (w_do_pop)  r_rd <= AW'(r_rd + 1'b1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/jt51_ch_wr_sched.sv
//------------------------------------------------------------------------------
// jt51_ch_wr_sched : queues CPU channel-register writes and issues each one
//                    while the channel shift register sits on its target slot
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jt51_ch_wr_sched
   import jt51_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       wr,
   input  logic       a0,
   input  logic [7:0] cpu_din,
   output logic [7:0] din,
   output logic       up_rl_ch,
   output logic       up_fb_ch,
   output logic       up_con_ch,
   output logic       up_kc_ch,
   output logic       up_kf_ch,
   output logic       up_ams_ch,
   output logic       up_pms_ch,
   output logic [2:0] slot,
   output logic       busy,
   output logic       overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    r_addr;
   logic [2:0]    r_slot;
   stb_t          r_stb;
   logic [7:0]    r_din;
   logic          r_ovf;

   entry_t        w_head;
   entry_t        w_next;
   entry_t        w_cand;
   entry_t        w_push_data;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_push;
   logic          w_pop;
   logic          w_stb_active;
   logic          w_cand_vld;
   logic          w_issue;
   logic [2:0]    w_next_slot;

   assign w_stb_active = |r_stb;
   assign w_next_slot  = r_slot + 3'd1;
   assign w_push       = wr && a0 && (r_addr[7:5] == c_addr_rl[7:5]);
   assign w_push_data  = {r_addr[4:0], cpu_din};
   assign w_pop        = cen && w_stb_active;

   // While the head is strobing it pops on this edge, so the entry behind it
   // is the one that may issue next (back-to-back to consecutive channels).
   assign w_cand     = w_stb_active ? w_next : w_head;
   assign w_cand_vld = w_stb_active ? (w_count > CW'(1)) : !w_empty;
   assign w_issue    = w_cand_vld && (w_cand.addr[2:0] == w_next_slot);

   jt51_sched_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= 8'h00;
         r_slot <= 3'd0;
         r_stb  <= '0;
         r_din  <= 8'h00;
         r_ovf  <= 1'b0;
      end else begin
         if (wr && !a0) r_addr <= cpu_din;
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         if (cen) begin
            r_slot <= w_next_slot;
            if (w_issue) begin
               r_stb <= decode_fields(w_cand.addr);
               r_din <= w_cand.data;
            end else begin
               r_stb <= '0;
            end
         end
      end
   end

   assign din       = r_din;
   assign slot      = r_slot;
   assign overflow  = r_ovf;
   assign busy      = (w_count != '0) || w_stb_active;
   assign up_rl_ch  = r_stb[c_stb_rl];
   assign up_fb_ch  = r_stb[c_stb_fb];
   assign up_con_ch = r_stb[c_stb_con];
   assign up_kc_ch  = r_stb[c_stb_kc];
   assign up_kf_ch  = r_stb[c_stb_kf];
   assign up_ams_ch = r_stb[c_stb_ams];
   assign up_pms_ch = r_stb[c_stb_pms];

endmodule

`default_nettype wire

// File: tb/tb_jt51_ch_wr_sched.sv
//------------------------------------------------------------------------------
// tb_jt51_ch_wr_sched : self-checking bench for the channel write scheduler
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_jt51_ch_wr_sched;

   logic       clk = 1'b0;
   logic       rst, cen, wr, a0;
   logic [7:0] cpu_din, din;
   logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;
   logic [2:0] slot;
   logic       busy, overflow;
   logic [6:0] stbv;

   jt51_ch_wr_sched #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cen(cen), .wr(wr), .a0(a0), .cpu_din(cpu_din),
      .din(din), .up_rl_ch(up_rl_ch), .up_fb_ch(up_fb_ch), .up_con_ch(up_con_ch),
      .up_kc_ch(up_kc_ch), .up_kf_ch(up_kf_ch), .up_ams_ch(up_ams_ch),
      .up_pms_ch(up_pms_ch), .slot(slot), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   assign stbv = {up_pms_ch, up_ams_ch, up_kf_ch, up_kc_ch, up_con_ch, up_fb_ch, up_rl_ch};

   typedef struct packed {
      logic [6:0] stb;
      logic [7:0] din;
      logic [2:0] ch;
   } exp_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [6:0] stb;
      logic [2:0] ch;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_stb_cyc = 0;
   int   prev_stb_cyc = 0;
   int   stb_seen = 0;
   logic cen_s;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] model_stb(input logic [7:0] a);
      if (a >= 8'h20 && a <= 8'h27) return 7'b0000111;
      if (a >= 8'h28 && a <= 8'h2F) return 7'b0001000;
      if (a >= 8'h30 && a <= 8'h37) return 7'b0010000;
      if (a >= 8'h38 && a <= 8'h3F) return 7'b1100000;
      return 7'b0000000;
   endfunction

   // Every strobe period that starts on a cen edge must match the queue head
   always @(posedge clk) begin
      cyc++;
      cen_s = cen;
      #1;
      if (!rst && cen_s && stbv != 7'd0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got stb=%0h din=%0h slot=%0d, none expected",
                     stbv, din, slot);
         end else begin
            mon_e = sb.pop_front();
            chk("strobe_vec", {25'd0, stbv}, {25'd0, mon_e.stb});
            chk("strobe_din", {24'd0, din}, {24'd0, mon_e.din});
            chk("strobe_slot", {29'd0, slot}, {29'd0, mon_e.ch});
         end
         prev_stb_cyc = last_stb_cyc;
         last_stb_cyc = cyc;
         stb_seen++;
      end
   end

   task automatic cpu_wr(input logic a, input logic [7:0] d);
      @(negedge clk);
      wr = 1'b1; a0 = a; cpu_din = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
      sb.push_back('{stb: model_stb(a), din: d, ch: a[2:0]});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int lim, input string nm);
      int k = 0;
      while ((busy || sb.size() != 0) && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_pending"}, sb.size(), 32'd0);
   endtask

   task automatic wait_strobe(input int lim, input string nm);
      bit seen = 0;
      for (int k = 0; k < lim && !seen; k++) begin
         @(posedge clk);
         #2;
         if (stbv != 7'd0) seen = 1;
      end
      chk(nm, {31'd0, seen}, 32'd1);
   endtask

   vec_t       vt[10];
   logic [7:0] last_din;
   int         exp_slot;
   int         seen0;

   initial begin
      rst = 1'b1; cen = 1'b1; wr = 1'b0; a0 = 1'b0; cpu_din = 8'h00;
      vt[0] = '{8'h2B, 8'h5A, 7'b0001000, 3'd3};
      vt[1] = '{8'h20, 8'hC7, 7'b0000111, 3'd0};
      vt[2] = '{8'h27, 8'h81, 7'b0000111, 3'd7};
      vt[3] = '{8'h2D, 8'h3C, 7'b0001000, 3'd5};
      vt[4] = '{8'h30, 8'h11, 7'b0010000, 3'd0};
      vt[5] = '{8'h36, 8'hE2, 7'b0010000, 3'd6};
      vt[6] = '{8'h38, 8'hA5, 7'b1100000, 3'd0};
      vt[7] = '{8'h3F, 8'h0F, 7'b1100000, 3'd7};
      vt[8] = '{8'h1F, 8'h99, 7'b0000000, 3'd7};
      vt[9] = '{8'h40, 8'h77, 7'b0000000, 3'd0};

      // Reset state and free-running slot counter
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_slot", {29'd0, slot}, 32'd0);
      chk("rst_din", {24'd0, din}, 32'd0);
      chk("rst_stb", {25'd0, stbv}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      exp_slot = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         exp_slot = (exp_slot + 1) % 8;
         chk("slot_count", {29'd0, slot}, exp_slot);
         chk("idle_stb", {25'd0, stbv}, 32'd0);
      end
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Single writes from the table, including ignored addresses
      last_din = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (vt[i].stb != 7'd0)
            sb.push_back('{stb: vt[i].stb, din: vt[i].data, ch: vt[i].ch});
         cpu_wr(1'b0, vt[i].addr);
         cpu_wr(1'b1, vt[i].data);
         if (vt[i].stb != 7'd0) begin
            wait_strobe(8, "latency");
            last_din = vt[i].data;
            wait_idle(6, "single");
         end else begin
            seen0 = stb_seen;
            repeat (10) @(negedge clk);
            chk("ignored_busy", {31'd0, busy}, 32'd0);
            chk("ignored_nostb", stb_seen, seen0);
         end
         chk("din_hold", {24'd0, din}, {24'd0, last_din});
      end

      // Ordering: ch7 then ch0 on consecutive cen edges
      cen = 1'b0;
      push_exp(8'h3F, 8'h11);
      cpu_wr(1'b0, 8'h3F);
      cpu_wr(1'b1, 8'h11);
      push_exp(8'h38, 8'h22);
      cpu_wr(1'b0, 8'h38);
      cpu_wr(1'b1, 8'h22);
      chk("frozen_busy", {31'd0, busy}, 32'd1);
      cen = 1'b1;
      wait_idle(40, "order");
      chk("order_gap", last_stb_cyc - prev_stb_cyc, 32'd1);

      // Push on the pop edge of a full queue is accepted
      do_reset();
      cen = 1'b0;
      cpu_wr(1'b0, 8'h35);
      for (int i = 0; i < 4; i++) begin
         push_exp(8'h35, 8'h40 + 8'(i));
         cpu_wr(1'b1, 8'h40 + 8'(i));
      end
      chk("full_ovf_pre", {31'd0, overflow}, 32'd0);
      cen = 1'b1;
      wait_strobe(10, "full_first_strobe");
      push_exp(8'h35, 8'h44);
      cpu_wr(1'b1, 8'h44);
      chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
      wait_idle(80, "pushpop");

      // Overflow: DEPTH+1 pushes with cen held low
      cen = 1'b0;
      cpu_wr(1'b0, 8'h31);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) push_exp(8'h31, 8'h60 + 8'(i));
         cpu_wr(1'b1, 8'h60 + 8'(i));
      end
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      cen = 1'b1;
      wait_idle(80, "ovf_drain");
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Reset in the middle of a kf strobe
      do_reset();
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      push_exp(8'h33, 8'hB4);
      cpu_wr(1'b0, 8'h33);
      cpu_wr(1'b1, 8'hB4);
      wait_strobe(10, "kf_strobe");
      chk("kf_high", {31'd0, up_kf_ch}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_stb", {25'd0, stbv}, 32'd0);
      chk("midrst_din", {24'd0, din}, 32'd0);
      chk("midrst_slot", {29'd0, slot}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen0 = stb_seen;
      repeat (20) @(negedge clk);
      chk("postrst_nostb", stb_seen, seen0);
      chk("postrst_busy", {31'd0, busy}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
